// File: rtl/nav_pkg.sv
// Shared types and defaults for the maze-move sequencer.
//   nav_state_t : sequencer FSM states
//   NAV_*       : default speed ceiling, ramp step and fast-decel multiplier
//   fast_step() : saturating RAMP_INC * FAST_MULT used as the fast-decel step
package nav_pkg;

    localparam int unsigned SPD_W  = 11;
    localparam int unsigned MULT_W = 3;
    localparam int unsigned PROD_W = SPD_W + MULT_W;

    localparam logic [SPD_W-1:0]  NAV_MAX_SPD   = 11'h2A0;
    localparam logic [SPD_W-1:0]  NAV_RAMP_INC  = 11'd18;
    localparam logic [MULT_W-1:0] NAV_FAST_MULT = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDNG     = 3'd1,
        RAMP_UP  = 3'd2,
        DEC_NORM = 3'd3,
        DEC_FAST = 3'd4
    } nav_state_t;

    // Product saturates to the full speed range rather than wrapping.
    function automatic logic [SPD_W-1:0] fast_step(
        input logic [SPD_W-1:0]  inc,
        input logic [MULT_W-1:0] mult
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(inc) * PROD_W'(mult);
        if (prod > PROD_W'({SPD_W{1'b1}})) begin
            return {SPD_W{1'b1}};
        end
        return prod[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/nav_spd_ramp.sv
// Saturating up/down speed accumulator.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : force speed to zero (highest priority)
//   inc         : add step, clamped at MAX_SPD
//   dec         : subtract step, clamped at zero
//   step        : step magnitude
//   spd         : registered speed
//   spd_nxt_c   : combinational next-cycle speed (lets the parent register
//                 flags that track spd in the same cycle)
module nav_spd_ramp
    import nav_pkg::*;
#(
    parameter logic [SPD_W-1:0] MAX_SPD = NAV_MAX_SPD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic [SPD_W-1:0] step,
    output logic [SPD_W-1:0] spd,
    output logic [SPD_W-1:0] spd_nxt_c
);

    localparam int unsigned SUM_W = SPD_W + 1;

    logic [SPD_W-1:0] r_spd;
    logic [SUM_W-1:0] w_sum;
    logic [SPD_W-1:0] w_up;
    logic [SPD_W-1:0] w_dn;

    // One extra bit on the sum so the ceiling compare never sees a wrap.
    always_comb begin
        w_sum = SUM_W'(r_spd) + SUM_W'(step);
        w_up  = (w_sum > SUM_W'(MAX_SPD)) ? MAX_SPD : w_sum[SPD_W-1:0];
        w_dn  = (r_spd > step) ? (r_spd - step) : '0;
    end

    always_comb begin
        spd_nxt_c = r_spd;
        if (clr) begin
            spd_nxt_c = '0;
        end else if (inc) begin
            spd_nxt_c = w_up;
        end else if (dec) begin
            spd_nxt_c = w_dn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd <= '0;
        end else begin
            r_spd <= spd_nxt_c;
        end
    end

    assign spd = r_spd;

endmodule

// File: rtl/nav_sequencer.sv
// Sequences the heading PID for one maze move: heading-only turns, forward
// moves with a speed ramp, and termination on heading convergence, wall ahead
// or a requested side opening.
//   clk, rst            : clock, synchronous active-high reset
//   strt_hdng, strt_mv  : start commands, honoured only in IDLE
//   stp_lft, stp_rght   : stop-at-opening requests, sampled with strt_mv
//   hdng_vld            : paces every speed update
//   at_hdng             : PID heading converged
//   lft_opn, rght_opn   : side openings
//   frwrd_opn           : path ahead clear
//   moving              : PID enable
//   frwrd_spd           : forward speed to the PID
//   mv_cmplt            : one-cycle move-complete pulse
//   en_fusion           : speed above half the ceiling
module nav_sequencer
    import nav_pkg::*;
#(
    parameter logic [SPD_W-1:0]  MAX_SPD   = NAV_MAX_SPD,
    parameter logic [SPD_W-1:0]  RAMP_INC  = NAV_RAMP_INC,
    parameter logic [MULT_W-1:0] FAST_MULT = NAV_FAST_MULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_hdng,
    input  logic             strt_mv,
    input  logic             stp_lft,
    input  logic             stp_rght,
    input  logic             hdng_vld,
    input  logic             at_hdng,
    input  logic             lft_opn,
    input  logic             rght_opn,
    input  logic             frwrd_opn,
    output logic             moving,
    output logic [SPD_W-1:0] frwrd_spd,
    output logic             mv_cmplt,
    output logic             en_fusion
);

    localparam logic [SPD_W-1:0] FAST_STEP = fast_step(RAMP_INC, FAST_MULT);
    localparam logic [SPD_W-1:0] HALF_SPD  = MAX_SPD >> 1;

    nav_state_t r_state;
    nav_state_t w_nxt_state;

    logic r_stp_lft;
    logic r_stp_rght;
    logic r_lft_prev;
    logic r_rght_prev;
    logic r_moving;
    logic r_mv_cmplt;
    logic r_en_fusion;

    logic             w_lft_rise;
    logic             w_rght_rise;
    logic             w_side_stop;
    logic             w_cmplt;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic [SPD_W-1:0] w_step;
    logic [SPD_W-1:0] w_spd;
    logic [SPD_W-1:0] w_spd_nxt;
    logic             w_start_mv;

    // Side-opening rising edges against the previous-cycle samples.
    assign w_lft_rise  = lft_opn  & ~r_lft_prev;
    assign w_rght_rise = rght_opn & ~r_rght_prev;
    assign w_side_stop = (r_stp_lft & w_lft_rise) | (r_stp_rght & w_rght_rise);

    // Next state and speed-ramp controls; speed updates follow the current
    // state, so a transition coinciding with hdng_vld still applies the old
    // state's step.
    always_comb begin
        w_nxt_state = r_state;
        w_cmplt     = 1'b0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_step      = RAMP_INC;

        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (strt_hdng) begin
                    w_nxt_state = HDNG;
                end else if (strt_mv) begin
                    w_nxt_state = RAMP_UP;
                end
            end
            HDNG: begin
                w_clr = 1'b1;
                if (at_hdng) begin
                    w_nxt_state = IDLE;
                    w_cmplt     = 1'b1;
                end
            end
            RAMP_UP: begin
                w_inc = hdng_vld;
                if (!frwrd_opn) begin
                    w_nxt_state = DEC_FAST;
                end else if (w_side_stop) begin
                    w_nxt_state = DEC_NORM;
                end
            end
            DEC_NORM: begin
                w_dec = hdng_vld;
                if (w_spd == '0) begin
                    w_nxt_state = IDLE;
                    w_cmplt     = 1'b1;
                end else if (!frwrd_opn) begin
                    w_nxt_state = DEC_FAST;
                end
            end
            DEC_FAST: begin
                w_dec  = hdng_vld;
                w_step = FAST_STEP;
                if (w_spd == '0) begin
                    w_nxt_state = IDLE;
                    w_cmplt     = 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign w_start_mv = (r_state == IDLE) && (w_nxt_state == RAMP_UP);

    // State, output and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_moving    <= 1'b0;
            r_mv_cmplt  <= 1'b0;
            r_en_fusion <= 1'b0;
            r_stp_lft   <= 1'b0;
            r_stp_rght  <= 1'b0;
            r_lft_prev  <= 1'b0;
            r_rght_prev <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_moving    <= (w_nxt_state != IDLE);
            r_mv_cmplt  <= w_cmplt;
            r_en_fusion <= (w_spd_nxt > HALF_SPD);
            if (w_start_mv) begin
                // Seed the edge detectors so an already-open side is not an edge.
                r_stp_lft   <= stp_lft;
                r_stp_rght  <= stp_rght;
                r_lft_prev  <= lft_opn;
                r_rght_prev <= rght_opn;
            end else if (r_state == RAMP_UP) begin
                r_lft_prev  <= lft_opn;
                r_rght_prev <= rght_opn;
            end
        end
    end

    nav_spd_ramp #(
        .MAX_SPD (MAX_SPD)
    ) u_spd_ramp (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .inc       (w_inc),
        .dec       (w_dec),
        .step      (w_step),
        .spd       (w_spd),
        .spd_nxt_c (w_spd_nxt)
    );

    assign moving    = r_moving;
    assign frwrd_spd = w_spd;
    assign mv_cmplt  = r_mv_cmplt;
    assign en_fusion = r_en_fusion;

endmodule

// File: tb/tb_nav_sequencer.sv
// Scoreboard bench for nav_sequencer: stimulus pushes every expected change of
// the output tuple {moving, frwrd_spd, en_fusion, mv_cmplt}; the monitor pops
// and compares whenever that tuple changes.
module tb_nav_sequencer;

    typedef struct packed {
        logic        mv;
        logic [10:0] spd;
        logic        en;
        logic        cm;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght, hdng_vld;
    logic        at_hdng, lft_opn, rght_opn, frwrd_opn;
    logic        moving;
    logic [10:0] frwrd_spd;
    logic        mv_cmplt;
    logic        en_fusion;

    obs_t exp_q[$];
    obs_t prev = '0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_spd  = 0;

    nav_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .hdng_vld  (hdng_vld),
        .at_hdng   (at_hdng),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .moving    (moving),
        .frwrd_spd (frwrd_spd),
        .mv_cmplt  (mv_cmplt),
        .en_fusion (en_fusion)
    );

    always #5 clk = ~clk;

    task automatic push(input logic mv, input int spd, input logic en, input logic cm);
        obs_t o;
        o.mv  = mv;
        o.spd = 11'(spd);
        o.en  = en;
        o.cm  = cm;
        exp_q.push_back(o);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Monitor: any change of the observed tuple must match the next expectation.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        if (mon_en) begin
            cur = {moving, frwrd_spd, en_fusion, mv_cmplt};
            if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got mv=%0d spd=%0d en=%0d cm=%0d want no change",
                             cur.mv, cur.spd, cur.en, cur.cm);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        errors++;
                        $display("FAIL sb_compare: got mv=%0d spd=%0d en=%0d cm=%0d want mv=%0d spd=%0d en=%0d cm=%0d",
                                 cur.mv, cur.spd, cur.en, cur.cm, e.mv, e.spd, e.en, e.cm);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ramp-up pulse: +18, ceiling 672, fusion above 336.
    task automatic vld_up();
        int n;
        n = m_spd + 18;
        if (n > 672) n = 672;
        if (n != m_spd) begin
            m_spd = n;
            push(1'b1, n, (n > 336), 1'b0);
        end
        hdng_vld = 1'b1;
        @(negedge clk);
        hdng_vld = 1'b0;
    endtask

    task automatic vld_dn(input int step);
        int n;
        n = (m_spd > step) ? m_spd - step : 0;
        if (n != m_spd) begin
            m_spd = n;
            push(1'b1, n, (n > 336), 1'b0);
        end
        hdng_vld = 1'b1;
        @(negedge clk);
        hdng_vld = 1'b0;
    endtask

    // Called right after the pulse that brought speed to zero.
    task automatic expect_cmplt(input string name);
        push(1'b0, 0, 1'b0, 1'b1);
        push(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk({name, "_cmplt_hi"}, int'(mv_cmplt), 1);
        chk({name, "_moving_lo"}, int'(moving), 0);
        @(negedge clk);
        chk({name, "_cmplt_lo"}, int'(mv_cmplt), 0);
        tick(2);
    endtask

    task automatic start_mv(input logic sl, input logic sr);
        strt_mv  = 1'b1;
        stp_lft  = sl;
        stp_rght = sr;
        push(1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        strt_mv  = 1'b0;
        stp_lft  = 1'b0;
        stp_rght = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;
        hdng_vld = 1'b0; at_hdng = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
        frwrd_opn = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_spd", int'(frwrd_spd), 0);
        chk("rst_cmplt", int'(mv_cmplt), 0);
        chk("rst_fusion", int'(en_fusion), 0);
        mon_en = 1'b1;

        // Full ramp to the ceiling, with gaps and a dropped start command.
        start_mv(1'b0, 1'b0);
        chk("moving_n1", int'(moving), 1);
        for (int k = 1; k <= 40; k++) begin
            vld_up();
            if (k == 10) begin
                strt_hdng = 1'b1;
                @(negedge clk);
                strt_hdng = 1'b0;
            end
            if (k % 7 == 0) tick(3);
        end
        chk("ramp_ceiling", int'(frwrd_spd), 672);
        chk("ramp_fusion", int'(en_fusion), 1);

        // Wall ahead: fast decel, -72 per pulse to zero.
        frwrd_opn = 1'b0;
        tick(1);
        for (int k = 1; k <= 10; k++) vld_dn(72);
        frwrd_opn = 1'b1;
        expect_cmplt("fast");

        // Left opening already present is not an edge; a fresh edge stops.
        lft_opn = 1'b1;
        start_mv(1'b1, 1'b0);
        vld_up();
        vld_up();
        tick(2);
        vld_up();
        chk("no_early_stop", int'(frwrd_spd), 54);
        lft_opn = 1'b0;
        tick(1);
        lft_opn = 1'b1;
        tick(1);
        for (int k = 1; k <= 3; k++) vld_dn(18);
        expect_cmplt("norm_lft");
        lft_opn = 1'b0;
        tick(1);

        // Left edge and wall in the same cycle: fast decel wins.
        start_mv(1'b1, 1'b0);
        vld_up();
        vld_up();
        lft_opn   = 1'b1;
        frwrd_opn = 1'b0;
        tick(1);
        frwrd_opn = 1'b1;
        lft_opn   = 1'b0;
        vld_dn(72);
        expect_cmplt("prio");

        // Right opening stop.
        start_mv(1'b0, 1'b1);
        vld_up();
        rght_opn = 1'b1;
        tick(1);
        vld_dn(18);
        expect_cmplt("norm_rght");
        rght_opn = 1'b0;
        tick(1);

        // Both starts together: heading move, speed held at zero.
        strt_hdng = 1'b1;
        strt_mv   = 1'b1;
        push(1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        strt_hdng = 1'b0;
        strt_mv   = 1'b0;
        hdng_vld  = 1'b1;
        @(negedge clk);
        hdng_vld  = 1'b0;
        strt_mv   = 1'b1;
        @(negedge clk);
        strt_mv   = 1'b0;
        tick(2);
        chk("hdng_spd", int'(frwrd_spd), 0);
        at_hdng = 1'b1;
        push(1'b0, 0, 1'b0, 1'b1);
        push(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        at_hdng = 1'b0;
        chk("hdng_cmplt_hi", int'(mv_cmplt), 1);
        chk("hdng_moving_lo", int'(moving), 0);
        @(negedge clk);
        chk("hdng_cmplt_lo", int'(mv_cmplt), 0);
        tick(2);

        // Reset mid-ramp at 360: everything clears, no completion pulse.
        start_mv(1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) vld_up();
        chk("pre_rst_spd", int'(frwrd_spd), 360);
        rst = 1'b1;
        push(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        m_spd = 0;
        chk("mid_rst_moving", int'(moving), 0);
        chk("mid_rst_spd", int'(frwrd_spd), 0);
        chk("mid_rst_cmplt", int'(mv_cmplt), 0);
        chk("mid_rst_fusion", int'(en_fusion), 0);
        tick(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
